mem_dump_reader: RTL
====================

# mem_dump_reader

Hardware read-back engine for the data memory of the multicycle MIPS system. The core writes results through memory port 0. This block reads an address range back out through the otherwise idle port 1 (`addr1`/`dout1`, `wr_ena1` tied low at instantiation). It streams each word out over a valid/ready interface, which lets benches and on-chip checkers dump DMEM without hierarchical peeks.

## Interface
- `N`, 32, data word width (matches memory `N`).
- `ADDR_W`, 11, word-address width (matches memory `D_WIDTH`).

- `clk`  in  1  system clock; all state updates on rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a dump; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first word address (inclusive).
- `stop_addr`  in  ADDR_W+1  end address (exclusive); may equal 2^ADDR_W.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the dump completes.
- `mem_rd_addr`  out  ADDR_W  to memory `addr1`.
- `mem_rd_data`  in  N  from memory `dout1`; valid the cycle after the address is sampled.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  sink accepts the beat.
- `out_addr`  out  ADDR_W  address of the current beat.
- `out_data`  out  N  data of the current beat.
- `out_last`  out  1  final beat of the dump.

## Operation
- FSM states are IDLE, ISSUE, CAPTURE, SEND, DONE (plus CKSUM when configured).
- IDLE:
  - If `start`=1, latch `start_addr` into the address counter and `stop_addr` into the limit register, then go to ISSUE.
  - If the latched range is empty (`start_addr >= stop_addr`), go to DONE instead (CKSUM when configured).
- ISSUE: drive `mem_rd_addr` = counter, then go to CAPTURE.
- CAPTURE:
  - Register `mem_rd_data` into `out_data` and the counter into `out_addr`.
  - Set `out_last` when counter+1 == limit, with the comparison done at ADDR_W+1 bits.
  - Go to SEND.
- SEND:
  - Hold `out_valid`=1 with the beat registers stable until `out_ready`=1.
  - On handshake, if `out_last` is set, go to DONE; otherwise increment the counter and go to ISSUE.
  - No memory read is issued while a beat is stalled.
- DONE: assert `done` for one cycle, then go to IDLE.
- `start` is ignored in every state except IDLE; a new dump may start in the cycle after `done`.
- `mem_rd_addr` holds its last value outside ISSUE.
- The counter never wraps past 2^ADDR_W-1: `stop_addr`=2^ADDR_W ends the dump on address 2^ADDR_W-1.
- Reset values: state IDLE; `busy`, `done`, `out_valid`, and `out_last` are 0; `out_addr`, `out_data`, and `mem_rd_addr` are 0.
- Reset asserted mid-dump aborts immediately. The stalled beat is dropped and `done` is not pulsed.

## Timing
- Latency is 3 cycles per word with `out_ready` held high: ISSUE, CAPTURE, SEND.
- First `out_valid` is at the 3rd rising edge after the edge that samples `start`.
- `done` is high for the cycle immediately after the last handshake.
- For an empty range, `done` is high in the cycle after `start` is sampled.
- A K-word dump with no stalls takes 3K+1 cycles from start-sample to `done` deassert.

## Configuration
- `MEM_DUMP_CHECKSUM_EN` defined:
  - A 32-bit wrapping sum of every emitted data word is accumulated; it is cleared at start.
  - After the last data beat, CKSUM emits one extra beat with `out_addr`=all ones, `out_data`=sum, and `out_last`=1.
  - `out_last` is then not set on the last data beat.
  - An empty range emits only the checksum beat, with sum 0.
- Not defined: no CKSUM state and no extra beat; behaviour is exactly as above.

## Structure
- Package `mem_dump_pkg` holds the state enum, the default `ADDR_W`/`N`, and the `CKSUM_ADDR` all-ones constant.
- Sub-module `mem_dump_cksum` is the accumulator (clear, add-on-handshake, value). It is instantiated only under `MEM_DUMP_CHECKSUM_EN`.

## Test plan
- Basic dump:
  - Stimulus: preload DMEM[64..67]=10,20,30,40; `start_addr`=64, `stop_addr`=68, `out_ready`=1.
  - Response: 4 beats with addr 64..67, data 10,20,30,40, `out_last` on addr 67 only; first `out_valid` 3 edges after start; `done` 13 cycles after start-sample.
- Backpressure:
  - Stimulus: same range; `out_ready` low for 5 cycles during beat 2.
  - Response: `out_data`=20 and addr 65 held stable; `mem_rd_addr` does not advance; no lost or duplicated beats.
- Empty and inverted range:
  - Stimulus: start=stop=100, then start=120/stop=100.
  - Response: zero beats; `done` pulses one cycle after start each time.
- Top-of-memory boundary:
  - Stimulus: `start_addr`=2046, `stop_addr`=2048.
  - Response: beats for 2046 and 2047, last on 2047; no wrap to 0.
- Reset and start-while-busy:
  - Stimulus: pulse `start` during SEND of a 4-word dump; later deassert `rstb` mid-dump.
  - Response: the second `start` is ignored. On reset, all outputs go to 0 asynchronously, there is no `done`, and a fresh dump then runs correctly.
- Checksum (`MEM_DUMP_CHECKSUM_EN`):
  - Stimulus: the basic-dump range.
  - Response: 5 beats; the fifth has addr 0x7FF, data 100, `out_last`=1; the data beat at addr 67 has `out_last`=0.

Source files
------------

// File: rtl/mem_dump_pkg.sv
// rtl/mem_dump_pkg.sv - shared types and constants for the DMEM read-back engine
package mem_dump_pkg;

  localparam int DEF_N      = 32;
  localparam int DEF_ADDR_W = 11;

  // Wide enough for any ADDR_W; the top slices off the bits it needs.
  localparam logic [31:0] CKSUM_ADDR = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE,
    ST_CKSUM
  } state_t;

endpackage

// File: rtl/mem_dump_cksum.sv
// rtl/mem_dump_cksum.sv - wrapping sum of every data word handed to the sink
module mem_dump_cksum #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         i_clear,
  input  logic         i_add,
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_sum
);

  logic [N-1:0] r_sum;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - streams a DMEM address range out over valid/ready
// Define MEM_DUMP_CHECKSUM_EN to append a checksum beat after the data beats.
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   stop_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [N-1:0]      mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [N-1:0]      out_data,
  output logic              out_last
);

`ifdef MEM_DUMP_CHECKSUM_EN
  localparam state_t ST_AFTER = ST_CKSUM;
`else
  localparam state_t ST_AFTER = ST_DONE;
`endif
  localparam logic DIRECT_DONE = (ST_AFTER == ST_DONE);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W:0]   r_lim;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [N-1:0]      r_data;
  logic              r_last;

  logic w_empty;
  logic w_cnt_last;
  logic w_hs;
  logic w_last_beat;

  assign w_empty    = ({1'b0, start_addr} >= stop_addr);
  // Compared one bit wider so a limit of 2^ADDR_W ends on the top word.
  assign w_cnt_last = (({1'b0, r_cnt} + (ADDR_W+1)'(1)) == r_lim);
  assign w_hs       = r_valid && out_ready;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic         r_data_last;
  logic         w_ck_clear;
  logic         w_ck_add;
  logic [N-1:0] w_sum;

  assign w_ck_clear  = (r_state == ST_IDLE) && start;
  assign w_ck_add    = (r_state == ST_SEND) && w_hs;
  assign w_last_beat = r_data_last;

  mem_dump_cksum #(.N(N)) u_cksum (
    .clk     (clk),
    .rstb    (rstb),
    .i_clear (w_ck_clear),
    .i_add   (w_ck_add),
    .i_data  (r_data),
    .o_sum   (w_sum)
  );
`else
  assign w_last_beat = r_last;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_lim     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_addr <= '0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      r_data_last <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt  <= start_addr;
            r_lim  <= stop_addr;
            r_busy <= 1'b1;
            if (w_empty) begin
              r_state <= ST_AFTER;
              r_done  <= DIRECT_DONE;
            end else begin
              r_rd_addr <= start_addr;
              r_state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_data  <= mem_rd_data;
          r_addr  <= r_cnt;
          r_valid <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
          r_data_last <= w_cnt_last;
          r_last      <= 1'b0;
`else
          r_last <= w_cnt_last;
`endif
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          // The next read address only moves on a handshake, never during a stall.
          if (w_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (w_last_beat) begin
              r_state <= ST_AFTER;
              r_done  <= DIRECT_DONE;
            end else begin
              r_cnt     <= r_cnt + ADDR_W'(1);
              r_rd_addr <= r_cnt + ADDR_W'(1);
              r_state   <= ST_ISSUE;
            end
          end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        ST_CKSUM: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_addr  <= CKSUM_ADDR[ADDR_W-1:0];
            r_data  <= w_sum;
            r_last  <= 1'b1;
          end else if (out_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign mem_rd_addr = r_rd_addr;
  assign out_valid   = r_valid;
  assign out_addr    = r_addr;
  assign out_data    = r_data;
  assign out_last    = r_last;

endmodule
